// File: rtl/hit_resolver_if.sv
// Interface bundling the per-triangle result stream (in) and the closest-hit record (out).
interface hit_resolver_if #(
  parameter int T_W   = 32,
  parameter int ID_W  = 16,
  parameter int CNT_W = 16
);
  // result beat stream from the intersection unit
  logic             i_valid;
  logic             o_ready;
  logic             i_hit;
  logic             i_invalid;
  logic [T_W-1:0]   i_t;
  logic [ID_W-1:0]  i_tri_id;
  logic             i_last;
  // closest-hit record towards shading
  logic             o_valid;
  logic             i_ready;
  logic             o_hit;
  logic [T_W-1:0]   o_t;
  logic [ID_W-1:0]  o_tri_id;
  logic [CNT_W-1:0] o_tri_count;
  logic [CNT_W-1:0] o_inv_count;

  // resolver side
  modport slave (
    input  i_valid, i_hit, i_invalid, i_t, i_tri_id, i_last, i_ready,
    output o_ready, o_valid, o_hit, o_t, o_tri_id, o_tri_count, o_inv_count
  );

  // producer/consumer side
  modport master (
    output i_valid, i_hit, i_invalid, i_t, i_tri_id, i_last, i_ready,
    input  o_ready, o_valid, o_hit, o_t, o_tri_id, o_tri_count, o_inv_count
  );
endinterface

// File: rtl/hit_resolver.sv
// Closest-hit resolver: accumulates per-triangle results of one ray and
// presents a single registered nearest-hit record with valid/ready.
module hit_resolver #(
  parameter int                     T_W   = 32,
  parameter int                     ID_W  = 16,
  parameter int                     CNT_W = 16,
  parameter logic signed [T_W-1:0]  MIN_T = {T_W{1'b0}}
) (
  input  logic           i_clk,
  input  logic           i_rst,
  hit_resolver_if.slave  bus
);

  // "No hit" distance: largest positive signed value.
  localparam logic signed [T_W-1:0] T_NONE  = {1'b0, {(T_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  state_t                 r_state, w_state_nxt;
  logic signed [T_W-1:0]  r_best_t, w_best_t_nxt;
  logic [ID_W-1:0]        r_best_id, w_best_id_nxt;
  logic                   r_hit, w_hit_nxt;
  logic [CNT_W-1:0]       r_tri_cnt, w_tri_cnt_nxt;
  logic [CNT_W-1:0]       r_inv_cnt, w_inv_cnt_nxt;

  logic                   w_accept;
  logic                   w_qual;
  logic                   w_closer;

  assign w_accept = bus.i_valid & (r_state == ST_ACCUM);
  // Invalid (overflow / div-by-0) beats never qualify, even with i_hit set.
  assign w_qual   = bus.i_hit & ~bus.i_invalid & ($signed(bus.i_t) > MIN_T);
  // Strict compare keeps the earlier triangle on equal distance.
  assign w_closer = w_qual & ($signed(bus.i_t) < r_best_t);

  // Next-state and next best-hit/counter values.
  always_comb begin
    w_state_nxt   = r_state;
    w_best_t_nxt  = r_best_t;
    w_best_id_nxt = r_best_id;
    w_hit_nxt     = r_hit;
    w_tri_cnt_nxt = r_tri_cnt;
    w_inv_cnt_nxt = r_inv_cnt;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept) begin
          w_tri_cnt_nxt = sat_inc(r_tri_cnt);
          if (bus.i_invalid) begin
            w_inv_cnt_nxt = sat_inc(r_inv_cnt);
          end else begin
            w_inv_cnt_nxt = r_inv_cnt;
          end
          if (w_closer) begin
            w_best_t_nxt  = $signed(bus.i_t);
            w_best_id_nxt = bus.i_tri_id;
            w_hit_nxt     = 1'b1;
          end else begin
            w_hit_nxt     = r_hit;
          end
          if (bus.i_last) begin
            w_state_nxt = ST_OUT;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_OUT: begin
        if (bus.i_ready) begin
          // Record consumed: start the next ray from a clean slate.
          w_state_nxt   = ST_ACCUM;
          w_best_t_nxt  = T_NONE;
          w_best_id_nxt = {ID_W{1'b0}};
          w_hit_nxt     = 1'b0;
          w_tri_cnt_nxt = {CNT_W{1'b0}};
          w_inv_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_state_nxt   = ST_OUT;
        end
      end
      default: begin
        w_state_nxt   = ST_ACCUM;
        w_best_t_nxt  = T_NONE;
        w_best_id_nxt = {ID_W{1'b0}};
        w_hit_nxt     = 1'b0;
        w_tri_cnt_nxt = {CNT_W{1'b0}};
        w_inv_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and best-hit registers; reset discards any partial ray.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_ACCUM;
      r_best_t  <= T_NONE;
      r_best_id <= {ID_W{1'b0}};
      r_hit     <= 1'b0;
      r_tri_cnt <= {CNT_W{1'b0}};
      r_inv_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_best_t  <= w_best_t_nxt;
      r_best_id <= w_best_id_nxt;
      r_hit     <= w_hit_nxt;
      r_tri_cnt <= w_tri_cnt_nxt;
      r_inv_cnt <= w_inv_cnt_nxt;
    end
  end

  // Outputs come straight from registers.
  assign bus.o_ready     = (r_state == ST_ACCUM);
  assign bus.o_valid     = (r_state == ST_OUT);
  assign bus.o_hit       = r_hit;
  assign bus.o_t         = r_best_t;
  assign bus.o_tri_id    = r_best_id;
  assign bus.o_tri_count = r_tri_cnt;
  assign bus.o_inv_count = r_inv_cnt;

endmodule
